// File: rtl/handle_check.sv
// Handle / check-field capture and verification for the 6C tag access command path.
// Serially captures a handle and a check byte, kicks the handle CRC verifier,
// waits (bounded) for its completion, then reports pass/fail with a result code.
module handle_check #(
   parameter int unsigned HANDLE_W = 16,
   parameter int unsigned CHECK_W  = 8,
   parameter int unsigned TIMEOUT  = 32,
   parameter int unsigned CNT_W    = 5
) (
   input  logic                ver_clk,
   input  logic                rst_n,
   input  logic                new_cmd,
   input  logic                bit_valid,
   input  logic                bit_data,
   input  logic [HANDLE_W-1:0] handle,
   input  logic [CHECK_W-1:0]  ver_code,
   input  logic                ver_done,
   output logic                ver_pulse,
   output logic [HANDLE_W-1:0] rx_handle,
   output logic [CHECK_W-1:0]  rx_check,
   output logic                chk_busy,
   output logic                chk_done,
   output logic                chk_ok,
   output logic [1:0]          err_code
);

   typedef enum logic [2:0] {
      StIdle, StRxHandle, StRxCheck, StVerStart, StVerWait, StCompare, StDone
   } state_e;

   localparam logic [CNT_W-1:0] HandleLast  = CNT_W'(HANDLE_W - 1);
   localparam logic [CNT_W-1:0] CheckLast   = CNT_W'(CHECK_W - 1);
   // Counter value on the last waiting cycle: the increment that would make it
   // reach TIMEOUT-1 ends the wait, so DONE starts TIMEOUT cycles after ver_pulse.
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 2);

   localparam logic [1:0] ErrOk      = 2'b00;
   localparam logic [1:0] ErrHandle  = 2'b01;
   localparam logic [1:0] ErrCode    = 2'b10;
   localparam logic [1:0] ErrTimeout = 2'b11;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    bcnt_q, bcnt_d;
   logic [CNT_W-1:0]    tcnt_q, tcnt_d;
   logic [HANDLE_W-1:0] rx_handle_d;
   logic [CHECK_W-1:0]  rx_check_d;
   logic                ver_pulse_d, chk_busy_d, chk_done_d, chk_ok_d;
   logic [1:0]          err_code_d;

   // State register
   always_ff @(posedge ver_clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; new_cmd aborts from any state
   always_comb begin
      state_d = state_q;
      if (new_cmd) begin
         state_d = StRxHandle;
      end else begin
         case (state_q)
            StIdle:     state_d = StIdle;
            StRxHandle: if (bit_valid && bcnt_q == HandleLast) state_d = StRxCheck;
            StRxCheck:  if (bit_valid && bcnt_q == CheckLast) state_d = StVerStart;
            StVerStart: state_d = StVerWait;
            StVerWait: begin
               if (ver_done)                  state_d = StCompare;
               else if (tcnt_q == TimeoutLast) state_d = StDone;
            end
            StCompare:  state_d = StDone;
            StDone:     state_d = StDone;
            default:    state_d = StIdle;
         endcase
      end
   end

   // Counters and shift registers next values
   always_comb begin
      bcnt_d      = bcnt_q;
      tcnt_d      = tcnt_q;
      rx_handle_d = rx_handle;
      rx_check_d  = rx_check;
      if (new_cmd) begin
         bcnt_d      = '0;
         tcnt_d      = '0;
         rx_handle_d = '0;
         rx_check_d  = '0;
      end else begin
         case (state_q)
            StRxHandle: begin
               if (bit_valid) begin
                  rx_handle_d = {rx_handle[HANDLE_W-2:0], bit_data};
                  bcnt_d      = (bcnt_q == HandleLast) ? '0 : bcnt_q + 1'b1;
               end
            end
            StRxCheck: begin
               if (bit_valid) begin
                  rx_check_d = {rx_check[CHECK_W-2:0], bit_data};
                  bcnt_d     = (bcnt_q == CheckLast) ? '0 : bcnt_q + 1'b1;
               end
            end
            StVerStart: tcnt_d = '0;
            StVerWait:  if (!ver_done) tcnt_d = tcnt_q + 1'b1;
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge ver_clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q    <= '0;
         tcnt_q    <= '0;
         rx_handle <= '0;
         rx_check  <= '0;
      end else begin
         bcnt_q    <= bcnt_d;
         tcnt_q    <= tcnt_d;
         rx_handle <= rx_handle_d;
         rx_check  <= rx_check_d;
      end
   end

   // Output next values, decoded from the upcoming state so outputs stay registered
   always_comb begin
      ver_pulse_d = (state_d == StVerStart);
      chk_busy_d  = !(state_d == StIdle || state_d == StDone);
      chk_done_d  = (state_d == StDone) && (state_q != StDone);
      chk_ok_d    = chk_ok;
      err_code_d  = err_code;
      if (new_cmd) begin
         chk_ok_d   = 1'b0;
         err_code_d = ErrOk;
      end else if (state_q == StCompare) begin
         if (rx_handle != handle) begin
            chk_ok_d   = 1'b0;
            err_code_d = ErrHandle;
         end else if (rx_check != ver_code) begin
            chk_ok_d   = 1'b0;
            err_code_d = ErrCode;
         end else begin
            chk_ok_d   = 1'b1;
            err_code_d = ErrOk;
         end
      end else if (state_q == StVerWait && state_d == StDone) begin
         chk_ok_d   = 1'b0;
         err_code_d = ErrTimeout;
      end
   end

   // Output registers
   always_ff @(posedge ver_clk or negedge rst_n) begin
      if (!rst_n) begin
         ver_pulse <= 1'b0;
         chk_busy  <= 1'b0;
         chk_done  <= 1'b0;
         chk_ok    <= 1'b0;
         err_code  <= ErrOk;
      end else begin
         ver_pulse <= ver_pulse_d;
         chk_busy  <= chk_busy_d;
         chk_done  <= chk_done_d;
         chk_ok    <= chk_ok_d;
         err_code  <= err_code_d;
      end
   end

endmodule

// File: tb/tb_handle_check.sv
// Bench for handle_check: directed vector table plus randomized frames checked
// against a result model derived from the comparison rules.
module tb_handle_check;

   localparam int TIMEOUT = 32;

   logic        ver_clk = 1'b0;
   logic        rst_n, new_cmd, bit_valid, bit_data, ver_done;
   logic [15:0] handle;
   logic [7:0]  ver_code;
   logic        ver_pulse, chk_busy, chk_done, chk_ok;
   logic [15:0] rx_handle;
   logic [7:0]  rx_check;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   int done_cnt = 0;

   typedef struct {
      logic [15:0] rx_h;
      logic [7:0]  rx_c;
      logic [15:0] hdl;
      logic [7:0]  code;
      int          delay;     // cycles from ver_pulse to ver_done; -1 = never
      int          pre_bits;  // bits sent before an aborting new_cmd; 0 = none
      int unsigned gap_max;
      logic        exp_ok;
      logic [1:0]  exp_err;
   } vec_t;

   vec_t vecs[8];

   handle_check dut (
      .ver_clk   (ver_clk),
      .rst_n     (rst_n),
      .new_cmd   (new_cmd),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .handle    (handle),
      .ver_code  (ver_code),
      .ver_done  (ver_done),
      .ver_pulse (ver_pulse),
      .rx_handle (rx_handle),
      .rx_check  (rx_check),
      .chk_busy  (chk_busy),
      .chk_done  (chk_done),
      .chk_ok    (chk_ok),
      .err_code  (err_code)
   );

   always #5 ver_clk = ~ver_clk;

   // Count cycles with ver_pulse / chk_done high
   always @(negedge ver_clk) begin
      if (ver_pulse) pulse_cnt <= pulse_cnt + 1;
      if (chk_done)  done_cnt  <= done_cnt + 1;
   end

   task automatic tick();
      @(posedge ver_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Result model: timeout, then handle, then code, else pass
   function automatic logic [2:0] model(input vec_t v);
      if (v.delay < 0)       return {1'b0, 2'b11};
      if (v.rx_h != v.hdl)   return {1'b0, 2'b01};
      if (v.rx_c != v.code)  return {1'b0, 2'b10};
      return {1'b1, 2'b00};
   endfunction

   task automatic noise();
      bit_valid = 1'($urandom_range(0, 1));
      bit_data  = 1'($urandom_range(0, 1));
   endtask

   task automatic send_bit(input logic b, input int unsigned gap_max);
      repeat ($urandom_range(0, gap_max)) tick();
      bit_valid = 1'b1;
      bit_data  = b;
      tick();
      bit_valid = 1'b0;
      bit_data  = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int          p0, d0, n;
      logic [23:0] frame;
      p0 = pulse_cnt;
      d0 = done_cnt;
      handle   = v.hdl;
      ver_code = ~v.code;
      new_cmd = 1'b1;
      tick();
      new_cmd = 1'b0;
      check({tag, " busy after new_cmd"}, chk_busy, 1);
      check({tag, " err cleared"}, err_code, 0);
      check({tag, " ok cleared"}, chk_ok, 0);
      if (v.pre_bits > 0) begin
         for (int i = 0; i < v.pre_bits; i++) send_bit(1'($urandom_range(0, 1)), v.gap_max);
         // Abort with a simultaneous valid bit, which must be discarded
         new_cmd   = 1'b1;
         bit_valid = 1'b1;
         bit_data  = 1'b1;
         tick();
         new_cmd   = 1'b0;
         bit_valid = 1'b0;
         check({tag, " rx_handle after abort"}, rx_handle, 0);
      end
      frame = {v.rx_h, v.rx_c};
      for (int i = 23; i >= 0; i--) send_bit(frame[i], v.gap_max);
      check({tag, " ver_pulse after last bit"}, ver_pulse, 1);
      check({tag, " busy in ver_start"}, chk_busy, 1);
      noise();
      tick();
      check({tag, " ver_pulse one cycle"}, ver_pulse, 0);
      if (v.delay < 0) begin
         n = 1;
         while (!chk_done && n < TIMEOUT + 16) begin
            noise();
            tick();
            n++;
         end
         check({tag, " timeout latency"}, n, TIMEOUT);
      end else begin
         for (int i = 1; i < v.delay; i++) begin
            noise();
            tick();
         end
         ver_done = 1'b1;
         ver_code = v.code;
         n = 0;
         do begin
            noise();
            tick();
            n++;
         end while (!chk_done && n < 40);
         check({tag, " done latency"}, n, 2);
      end
      bit_valid = 1'b0;
      ver_done  = 1'b0;
      check({tag, " chk_ok"}, chk_ok, v.exp_ok);
      check({tag, " err_code"}, err_code, v.exp_err);
      check({tag, " rx_handle"}, rx_handle, v.rx_h);
      check({tag, " rx_check"}, rx_check, v.rx_c);
      check({tag, " pulse count"}, pulse_cnt - p0, 1);
      check({tag, " busy in done"}, chk_busy, 0);
      tick();
      tick();
      check({tag, " chk_done single"}, chk_done, 0);
      check({tag, " done count"}, done_cnt - d0, 1);
      check({tag, " ok held"}, chk_ok, v.exp_ok);
      check({tag, " err held"}, err_code, v.exp_err);
   endtask

   initial begin
      vec_t v;
      logic [2:0] m;
      int p0, d0;

      vecs[0] = '{16'hA5C3, 8'h5E, 16'hA5C3, 8'h5E, 17, 0, 0, 1'b1, 2'b00};
      vecs[1] = '{16'hA5C2, 8'h5E, 16'hA5C3, 8'h5E, 17, 0, 2, 1'b0, 2'b01};
      vecs[2] = '{16'hA5C2, 8'h5F, 16'hA5C3, 8'h5E, 9, 0, 2, 1'b0, 2'b01};
      vecs[3] = '{16'hA5C3, 8'h5F, 16'hA5C3, 8'h5E, 5, 0, 2, 1'b0, 2'b10};
      vecs[4] = '{16'hA5C3, 8'h5E, 16'hA5C3, 8'h5E, -1, 0, 1, 1'b0, 2'b11};
      vecs[5] = '{16'hA5C3, 8'h5E, 16'hA5C3, 8'h5E, 3, 10, 3, 1'b1, 2'b00};
      vecs[6] = '{16'h0000, 8'h00, 16'h0000, 8'h00, 1, 0, 0, 1'b1, 2'b00};
      vecs[7] = '{16'hFFFF, 8'hFF, 16'hFFFF, 8'hFF, 31, 0, 1, 1'b1, 2'b00};

      rst_n     = 1'b0;
      new_cmd   = 1'b0;
      bit_valid = 1'b0;
      bit_data  = 1'b0;
      ver_done  = 1'b0;
      handle    = '0;
      ver_code  = '0;
      repeat (2) @(posedge ver_clk);
      #1;
      check("reset ver_pulse", ver_pulse, 0);
      check("reset rx_handle", rx_handle, 0);
      check("reset rx_check", rx_check, 0);
      check("reset busy", chk_busy, 0);
      check("reset chk_done", chk_done, 0);
      check("reset chk_ok", chk_ok, 0);
      check("reset err_code", err_code, 0);
      rst_n = 1'b1;
      tick();

      // Bits in IDLE are ignored
      p0 = pulse_cnt;
      for (int i = 0; i < 30; i++) send_bit(1'b1, 0);
      check("idle rx_handle", rx_handle, 0);
      check("idle busy", chk_busy, 0);
      check("idle pulse count", pulse_cnt - p0, 0);

      for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      for (int k = 0; k < 20; k++) begin
         v.hdl  = 16'($urandom);
         v.code = 8'($urandom);
         v.rx_h = ($urandom_range(0, 3) == 0) ? v.hdl ^ (16'h1 << $urandom_range(0, 15)) : v.hdl;
         v.rx_c = ($urandom_range(0, 3) == 0) ? v.code ^ (8'h1 << $urandom_range(0, 7)) : v.code;
         v.delay    = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 31));
         v.pre_bits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) : 0;
         v.gap_max  = 3;
         m = model(v);
         v.exp_ok  = m[2];
         v.exp_err = m[1:0];
         run_frame(v, $sformatf("rand%0d", k));
      end

      // Asynchronous reset while waiting for the verifier
      p0 = pulse_cnt;
      handle   = 16'hA5C3;
      ver_code = 8'h5E;
      new_cmd = 1'b1;
      tick();
      new_cmd = 1'b0;
      for (int i = 23; i >= 0; i--) send_bit(1'(24'hA5C35E >> i), 1);
      repeat (5) tick();
      check("pre-reset busy", chk_busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async ver_pulse", ver_pulse, 0);
      check("async rx_handle", rx_handle, 0);
      check("async rx_check", rx_check, 0);
      check("async busy", chk_busy, 0);
      check("async chk_done", chk_done, 0);
      check("async chk_ok", chk_ok, 0);
      check("async err_code", err_code, 0);
      repeat (3) @(posedge ver_clk);
      #1;
      rst_n = 1'b1;
      d0 = done_cnt;
      ver_done = 1'b1;
      repeat (40) tick();
      ver_done = 1'b0;
      check("post-reset no chk_done", done_cnt - d0, 0);
      check("post-reset idle", chk_busy, 0);
      check("post-reset pulse count", pulse_cnt - p0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
